// File: rtl/window_generator_3x3_if.sv
// Pixel-stream and 3x3-window bundle between the raster source, the window
// generator and the downstream tap stage.
interface window_generator_3x3_if #(
   parameter int bitwidth = 8
);
   logic [bitwidth-1:0] pixel_in;
   logic                pixel_valid;
   logic [bitwidth-1:0] values [0:8];
   logic                values_valid;
   logic                frame_done;

   modport master (
      output pixel_in,
      output pixel_valid,
      input  values,
      input  values_valid,
      input  frame_done
   );

   modport slave (
      input  pixel_in,
      input  pixel_valid,
      output values,
      output values_valid,
      output frame_done
   );
endinterface

// File: rtl/window_generator_3x3.sv
// Streaming 3x3 sliding-window generator: two row line buffers feed a 3x3
// register window; a registered strobe marks each complete neighbourhood.
module window_generator_3x3 #(
   parameter int bitwidth    = 8,
   parameter int imageWidth  = 28,
   parameter int imageHeight = 28
) (
   input  logic                  clock,
   input  logic                  reset,
   window_generator_3x3_if.slave bus
);
   localparam int col_w = $clog2(imageWidth);
   localparam int row_w = $clog2(imageHeight);
   localparam logic [col_w-1:0] col_max = col_w'(imageWidth - 1);
   localparam logic [row_w-1:0] row_max = row_w'(imageHeight - 1);
   localparam logic [col_w-1:0] col_two = col_w'(2);
   localparam logic [row_w-1:0] row_two = row_w'(2);
   localparam logic [col_w-1:0] col_one = col_w'(1);
   localparam logic [row_w-1:0] row_one = row_w'(1);

   if (imageWidth < 3) begin : g_bad_width
      $fatal(1, "window_generator_3x3: imageWidth must be >= 3");
   end
   if (imageHeight < 3) begin : g_bad_height
      $fatal(1, "window_generator_3x3: imageHeight must be >= 3");
   end

   logic [col_w-1:0]    col_r;
   logic [row_w-1:0]    row_r;
   logic [bitwidth-1:0] lb0_mem_r [0:imageWidth-1];
   logic [bitwidth-1:0] lb1_mem_r [0:imageWidth-1];
   logic [bitwidth-1:0] lb0_head_s;
   logic [bitwidth-1:0] lb1_head_s;
   logic [bitwidth-1:0] win_r      [0:8];
   logic [bitwidth-1:0] win_next_s [0:8];
   logic [bitwidth-1:0] values_r   [0:8];
   logic                values_valid_r;
   logic                frame_done_r;
   logic                accept_s;
   logic                qualify_s;
   logic                last_pixel_s;

   // Line buffers are addressed by column, so the slot about to be overwritten
   // still holds the same column of the previous row (read-before-write).
   assign lb0_head_s   = lb0_mem_r[col_r];
   assign lb1_head_s   = lb1_mem_r[col_r];
   assign accept_s     = bus.pixel_valid;
   assign qualify_s    = accept_s && (row_r >= row_two) && (col_r >= col_two);
   assign last_pixel_s = (row_r == row_max) && (col_r == col_max);

   // Raster position of the next accepted pixel.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col_r <= {col_w{1'b0}};
         row_r <= {row_w{1'b0}};
      end else if (accept_s) begin
         if (col_r == col_max) begin
            col_r <= {col_w{1'b0}};
            if (row_r == row_max) begin
               row_r <= {row_w{1'b0}};
            end else begin
               row_r <= row_r + row_one;
            end
         end else begin
            col_r <= col_r + col_one;
         end
      end
   end

   // Cascaded row buffers; contents are left unreset and masked by row gating.
   always_ff @(posedge clock) begin
      if (accept_s) begin
         lb0_mem_r[col_r] <= bus.pixel_in;
         lb1_mem_r[col_r] <= lb0_head_s;
      end
   end

   // Next window: every row shifts left, new right column enters from the buffers.
   always_comb begin
      for (int k = 0; k < 9; k++) begin
         win_next_s[k] = win_r[k];
      end
      if (accept_s) begin
         for (int k = 0; k < 3; k++) begin
            win_next_s[3*k]     = win_r[3*k + 1];
            win_next_s[3*k + 1] = win_r[3*k + 2];
         end
         win_next_s[2] = lb1_head_s;
         win_next_s[5] = lb0_head_s;
         win_next_s[8] = bus.pixel_in;
      end else begin
         for (int k = 0; k < 9; k++) begin
            win_next_s[k] = win_r[k];
         end
      end
   end

   // Window registers and the registered output window / strobes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 9; k++) begin
            win_r[k]    <= {bitwidth{1'b0}};
            values_r[k] <= {bitwidth{1'b0}};
         end
         values_valid_r <= 1'b0;
         frame_done_r   <= 1'b0;
      end else begin
         win_r          <= win_next_s;
         values_valid_r <= qualify_s;
         frame_done_r   <= qualify_s && last_pixel_s;
         if (qualify_s) begin
            values_r <= win_next_s;
         end
      end
   end

   assign bus.values       = values_r;
   assign bus.values_valid = values_valid_r;
   assign bus.frame_done   = frame_done_r;
endmodule

// File: tb/tb_window_generator_3x3.sv
// Self-checking bench: a 5x4 and a default 28x28 instance driven with random
// valid gaps and compared against a frame-image reference model.
module tb_window_generator_3x3;
   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   window_generator_3x3_if #(.bitwidth(8)) s_if ();
   window_generator_3x3_if #(.bitwidth(8)) b_if ();

   window_generator_3x3 #(.bitwidth(8), .imageWidth(5), .imageHeight(4)) u_small (
      .clock (clock),
      .reset (reset),
      .bus   (s_if.slave)
   );

   window_generator_3x3 #(.bitwidth(8), .imageWidth(28), .imageHeight(28)) u_big (
      .clock (clock),
      .reset (reset),
      .bus   (b_if.slave)
   );

   int          vec_cnt = 0;
   int          err_cnt = 0;
   int          img_w [2] = '{5, 28};
   int          img_h [2] = '{4, 28};
   int          pos   [2];
   logic [7:0]  img   [2][28][28];
   logic [71:0] last_win [2];
   int          win_cnt;
   int          done_cnt;
   bit          first_seen;
   logic [71:0] first_obs;
   logic [71:0] last_obs;

   task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] pack_obs(input int sel);
      logic [71:0] w;
      w = 72'h0;
      for (int k = 0; k < 9; k++) begin
         w[71 - 8*k -: 8] = (sel == 0) ? s_if.values[k] : b_if.values[k];
      end
      return w;
   endfunction

   task automatic clear_stats();
      win_cnt    = 0;
      done_cnt   = 0;
      first_seen = 1'b0;
      first_obs  = 72'h0;
      last_obs   = 72'h0;
   endtask

   // One clock: model predicts, inputs applied, outputs checked 1 time unit after the edge.
   task automatic step(input int sel, input bit v, input logic [7:0] p);
      int          r, c;
      logic        exp_v, exp_d, obs_v, obs_d;
      logic [71:0] obs_w;
      exp_v = 1'b0;
      exp_d = 1'b0;
      if (v) begin
         r = pos[sel] / img_w[sel];
         c = pos[sel] % img_w[sel];
         img[sel][r][c] = p;
         if (r >= 2 && c >= 2) begin
            exp_v = 1'b1;
            exp_d = (r == img_h[sel] - 1) && (c == img_w[sel] - 1);
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  last_win[sel][71 - 8*(3*i + j) -: 8] = img[sel][r - 2 + i][c - 2 + j];
               end
            end
         end
         pos[sel] = (pos[sel] + 1) % (img_w[sel] * img_h[sel]);
      end
      s_if.pixel_valid = (sel == 0) && v;
      s_if.pixel_in    = p;
      b_if.pixel_valid = (sel == 1) && v;
      b_if.pixel_in    = p;
      @(posedge clock);
      #1;
      s_if.pixel_valid = 1'b0;
      b_if.pixel_valid = 1'b0;
      obs_v = (sel == 0) ? s_if.values_valid : b_if.values_valid;
      obs_d = (sel == 0) ? s_if.frame_done   : b_if.frame_done;
      obs_w = pack_obs(sel);
      check_val("values_valid", {71'h0, obs_v}, {71'h0, exp_v});
      check_val("frame_done",   {71'h0, obs_d}, {71'h0, exp_d});
      check_val("values",       obs_w, last_win[sel]);
      if (obs_v) begin
         win_cnt++;
         if (!first_seen) begin
            first_seen = 1'b1;
            first_obs  = obs_w;
         end
         last_obs = obs_w;
      end
      if (obs_d) begin
         done_cnt++;
      end
   endtask

   task automatic check_zero();
      for (int s = 0; s < 2; s++) begin
         check_val("rst_values", pack_obs(s), 72'h0);
         check_val("rst_valid", {71'h0, (s == 0) ? s_if.values_valid : b_if.values_valid}, 72'h0);
         check_val("rst_done",  {71'h0, (s == 0) ? s_if.frame_done   : b_if.frame_done},   72'h0);
      end
   endtask

   task automatic do_reset(input int n);
      s_if.pixel_valid = 1'b0;
      b_if.pixel_valid = 1'b0;
      reset = 1'b1;
      #1;
      check_zero();
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         check_zero();
      end
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         pos[s]      = 0;
         last_win[s] = 72'h0;
      end
   endtask

   // Pixel k of the frame carries (base + k) mod 256; up to gmax idle cycles precede each pixel.
   task automatic send_frame(input int sel, input int base, input int gmax);
      int gaps;
      for (int k = 0; k < img_w[sel] * img_h[sel]; k++) begin
         gaps = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
         for (int g = 0; g < gaps; g++) begin
            step(sel, 1'b0, 8'($urandom));
         end
         step(sel, 1'b1, 8'(base + k));
      end
   endtask

   initial begin
      s_if.pixel_in    = 8'h00;
      s_if.pixel_valid = 1'b0;
      b_if.pixel_in    = 8'h00;
      b_if.pixel_valid = 1'b0;
      reset            = 1'b0;
      @(posedge clock);
      #1;
      do_reset(2);

      clear_stats();
      send_frame(0, 1, 0);
      check_val("basic_count", 72'(win_cnt), 72'd6);
      check_val("basic_done",  72'(done_cnt), 72'd1);
      check_val("basic_first", first_obs, 72'h01_02_03_06_07_08_0B_0C_0D);
      check_val("basic_last",  last_obs,  72'h08_09_0A_0D_0E_0F_12_13_14);

      clear_stats();
      send_frame(0, 1, 2);
      check_val("gap_count", 72'(win_cnt), 72'd6);
      check_val("gap_first", first_obs, 72'h01_02_03_06_07_08_0B_0C_0D);
      check_val("gap_last",  last_obs,  72'h08_09_0A_0D_0E_0F_12_13_14);

      clear_stats();
      send_frame(0, 1, 0);
      first_seen = 1'b0;
      send_frame(0, 100, 0);
      check_val("b2b_first2", first_obs, 72'h64_65_66_69_6A_6B_6E_6F_70);
      check_val("b2b_count",  72'(win_cnt), 72'd12);
      check_val("b2b_done",   72'(done_cnt), 72'd2);

      clear_stats();
      for (int k = 0; k < 9; k++) begin
         step(0, 1'b1, 8'(k + 1));
      end
      do_reset(3);
      send_frame(0, 1, 1);
      check_val("rst_count", 72'(win_cnt), 72'd6);
      check_val("rst_first", first_obs, 72'h01_02_03_06_07_08_0B_0C_0D);

      clear_stats();
      send_frame(1, 0, 1);
      check_val("big_count", 72'(win_cnt), 72'd676);
      check_val("big_done",  72'(done_cnt), 72'd1);
      check_val("big_last",  last_obs, 72'hD5_D6_D7_F1_F2_F3_0D_0E_0F);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
